program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time writer for the instruction ROM. The fetch path only ever reads that ROM; this block fills it.
- Accepts a byte stream through a valid/ready handshake, assembles 32-bit little-endian instruction words, and issues one-cycle write strobes with word-aligned byte addresses.
- Holds the processor via CpuHold until a complete image has been written.

Parameters:
- MEMORY_DEPTH, 32: number of instruction words in program memory; maximum legal image length.
- DATA_WIDTH, 32: instruction and address width; must be 32 (four bytes per word).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins a load; honoured in IDLE, DONE or ERROR.
- ByteIn  input  8  stream data byte.
- ByteValid  input  1  ByteIn is valid this cycle.
- ByteReady  output  1  loader accepts a byte this cycle; a transfer happens when ByteValid && ByteReady.
- WriteEnable  output  1  one-cycle write strobe to program memory.
- WriteAddress  output  DATA_WIDTH  byte address of the word being written (word index * 4; bits [1:0] always 0).
- WriteData  output  DATA_WIDTH  assembled instruction word.
- Busy  output  1  load in progress (LEN_LO..WRITE).
- Done  output  1  image loaded successfully; held until the next Start.
- Error  output  1  bad length header; held until the next Start.
- CpuHold  output  1  keeps the CPU in reset; deasserted only in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ByteReady=0, WriteEnable=0, WriteAddress=0, WriteData=0, Busy=0, Done=0, Error=0, CpuHold=1.
  - Internal byte counter, word counter and length register cleared.
- Stream format: 2-byte header N (word count, low byte first), then 4*N data bytes, each word least-significant byte first.
- States and transitions:
  - IDLE: ByteReady=0. Start -> LEN_LO.
  - LEN_LO: ByteReady=1. On transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: ByteReady=1. On transfer, latch N[15:8] and check N.
    - N==0 or N>MEMORY_DEPTH -> ERROR.
    - Otherwise -> DATA, with word index 0 and byte index 0.
  - DATA: ByteReady=1. Each transfer loads WriteData[8*k+7:8*k] with ByteIn, where k is the byte index 0..3, then increments the byte index. The transfer that carries byte 3 -> WRITE.
  - WRITE (exactly 1 cycle):
    - ByteReady=0, WriteEnable=1, WriteAddress={word index,2'b00}.
    - Word index increments at the end of the cycle.
    - If word index==N-1 -> DONE, otherwise -> DATA with byte index 0.
  - DONE: Done=1, CpuHold=0, ByteReady=0. Start -> LEN_LO, clearing Done and setting CpuHold=1 on the next edge.
  - ERROR: Error=1, CpuHold=1, ByteReady=0. Start -> LEN_LO, clearing Error.
- Start is ignored while Busy.
- ByteValid is ignored whenever ByteReady=0; such bytes are not consumed.
- Latency: the write strobe occurs in the cycle immediately after the transfer of the word's 4th byte.
- WriteData and WriteAddress hold their last values outside WRITE. Memory acts only on WriteEnable.
- ByteValid low stalls any receive state indefinitely; there is no timeout.
- Reset mid-load:
  - Immediate return to IDLE with reset values.
  - Words already written stay in memory.
  - A partial word is discarded and never written.
- Busy=1 exactly in LEN_LO, LEN_HI, DATA and WRITE.
- CpuHold=1 in every state except DONE.

Test Plan:
- Reset then Start; stream 02 00, 78 56 34 12, DD CC BB AA with ByteValid constant high:
  - Write 0x12345678 @0x0, then 0xAABBCCDD @0x4.
  - Exactly one WriteEnable cycle per word, and ByteReady=0 during each WRITE cycle.
  - Then Done=1, CpuHold=0.
- Same image with ByteValid toggled randomly:
  - Identical writes.
  - No byte lost or duplicated, and no bytes consumed while ByteReady=0.
- Header 00 00 -> ERROR with Error=1, CpuHold=1 and no WriteEnable. Header 21 00 (33 > 32) -> ERROR.
- Full image N=32 (20 00) with data word i = i:
  - 32 writes, the last being 0x0000001F @0x7C.
  - Then DONE.
  - A further byte offered while in DONE is not accepted.
- reset pulsed low after 6 data bytes of a 2-word load:
  - Only word 0 written.
  - Outputs at reset values.
  - A following Start and a full load succeed normally.
- Start pulses during DATA are ignored. A Start in DONE reloads the image, with CpuHold reasserted on the next cycle.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time writer that fills the instruction ROM from a byte stream
// Stream: 2-byte little-endian word count, then little-endian 32-bit words.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic                  CpuHold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] waddr_q, waddr_d;
  logic                  xfer;
  logic [15:0]           len_full;

  assign ByteReady    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign xfer         = ByteValid && ByteReady;
  assign len_full     = {ByteIn, len_q[7:0]};
  assign WriteEnable  = (state_q == S_WRITE);
  assign Busy         = ByteReady || (state_q == S_WRITE);
  assign Done         = (state_q == S_DONE);
  assign Error        = (state_q == S_ERROR);
  assign CpuHold      = (state_q != S_DONE);
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d    = S_LEN_LO;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, ByteIn};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == 16'd0 || len_full > MAX_LEN) begin
            state_d = S_ERROR;
          end else begin
            state_d    = S_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d[8*byte_idx_q +: 8] = ByteIn;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
            waddr_d = DATA_WIDTH'({word_idx_q, 2'b00});
          end
        end
      end
      S_WRITE: begin
        // byte_idx has already wrapped to 0, so the next word starts cleanly
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q == len_q - 16'd1) state_d = S_DONE;
        else                             state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a stream-level model
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        ByteReady, WriteEnable, Busy, Done, Error, CpuHold;
  logic [31:0] WriteAddress, WriteData;

  always #5 clk = ~clk;

  program_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .Busy(Busy), .Done(Done), .Error(Error), .CpuHold(CpuHold)
  );

  int chk_total = 0;
  int chk_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a load is a count of consumed header/data bytes plus a pending-write flag
  bit          m_busy, m_wr;
  int          m_result, m_hdr, m_bytes, m_words, m_n;
  logic [31:0] m_word, m_addr;

  function automatic void m_reset();
    m_busy = 0; m_wr = 0; m_result = 0; m_hdr = 0; m_bytes = 0; m_words = 0; m_n = 0;
    m_word = '0; m_addr = '0;
  endfunction

  task automatic m_step();
    if (m_wr) begin
      m_wr = 0;
      if (m_words == m_n) begin m_busy = 0; m_result = 1; end
    end else if (m_busy) begin
      if (ByteValid) begin
        if (m_hdr == 0) begin
          m_n = int'(ByteIn); m_hdr = 1;
        end else if (m_hdr == 1) begin
          m_n = m_n + int'(ByteIn) * 256; m_hdr = 2;
          if (m_n == 0 || m_n > 32) begin m_busy = 0; m_result = 2; end
        end else begin
          m_word[8*(m_bytes%4) +: 8] = ByteIn;
          m_bytes++;
          if (m_bytes % 4 == 0) begin
            m_wr = 1; m_addr = 32'((m_bytes/4 - 1) * 4); m_words++;
          end
        end
      end
    end else if (Start) begin
      m_busy = 1; m_result = 0; m_hdr = 0; m_bytes = 0; m_words = 0; m_n = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (rst_n) m_step();
    end
  end

  logic [31:0] dut_mem [0:31];
  int          we_count;
  logic [31:0] last_addr, last_data;

  initial begin
    forever begin
      @(negedge clk);
      chk("ready",  32'(ByteReady),    32'(m_busy && !m_wr));
      chk("we",     32'(WriteEnable),  32'(m_wr));
      chk("busy",   32'(Busy),         32'(m_busy));
      chk("done",   32'(Done),         32'(m_result == 1));
      chk("error",  32'(Error),        32'(m_result == 2));
      chk("hold",   32'(CpuHold),      32'(m_result != 1));
      chk("waddr",  WriteAddress,      m_addr);
      chk("wdata",  WriteData,         m_word);
      if (WriteEnable) begin
        we_count++;
        last_addr = WriteAddress;
        last_data = WriteData;
        dut_mem[WriteAddress[6:2]] = WriteData;
      end
    end
  end

  logic [31:0] img[$];
  logic [7:0]  stream[$];

  task automatic build();
    stream.delete();
    stream.push_back(8'(img.size()));
    stream.push_back(8'(img.size() >> 8));
    foreach (img[i]) for (int b = 0; b < 4; b++) stream.push_back(img[i][8*b +: 8]);
  endtask

  task automatic clear_log();
    we_count = 0;
    for (int i = 0; i < 32; i++) dut_mem[i] = 32'hDEADDEAD;
  endtask

  task automatic do_start();
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
  endtask

  task automatic send(input bit rnd, input int start_at);
    int  idx = 0;
    int  cyc = 0;
    bit  acc, st;
    st = 0;
    while (idx < stream.size() && cyc < 5000) begin
      @(negedge clk);
      ByteIn    = stream[idx];
      ByteValid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (idx == start_at && !st) begin Start = 1'b1; st = 1; end
      else Start = 1'b0;
      acc = ByteValid && ByteReady;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    @(negedge clk);
    ByteValid = 1'b0; Start = 1'b0;
    if (idx < stream.size()) chk("stream_stalled", 32'(idx), 32'(stream.size()));
  endtask

  task automatic wait_finish();
    int c = 0;
    while (!(Done || Error) && c < 40) begin @(negedge clk); c++; end
    if (c >= 40) chk("finish_timeout", 32'(c), 32'd0);
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    foreach (img[i]) if (dut_mem[i] !== img[i]) bad++;
    chk(name, 32'(bad), 32'd0);
    chk({name, "_count"}, 32'(we_count), 32'(img.size()));
  endtask

  task automatic check_reset_values();
    chk("rst_ready", 32'(ByteReady),   32'd0);
    chk("rst_we",    32'(WriteEnable), 32'd0);
    chk("rst_addr",  WriteAddress,     32'h0);
    chk("rst_data",  WriteData,        32'h0);
    chk("rst_busy",  32'(Busy),        32'd0);
    chk("rst_done",  32'(Done),        32'd0);
    chk("rst_err",   32'(Error),       32'd0);
    chk("rst_hold",  32'(CpuHold),     32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; m_reset();
    #1 check_reset_values();
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 check_reset_values();
    @(negedge clk); #2 rst_n = 1'b1;

    // basic two-word image, ByteValid held high
    clear_log(); do_start();
    img = '{32'h12345678, 32'hAABBCCDD}; build();
    send(0, -1); wait_finish();
    chk("t1_w0", dut_mem[0], 32'h12345678);
    chk("t1_w1", dut_mem[1], 32'hAABBCCDD);
    chk("t1_cnt", 32'(we_count), 32'd2);
    chk("t1_last_addr", last_addr, 32'h4);
    chk("t1_done", 32'(Done), 32'd1);
    chk("t1_hold", 32'(CpuHold), 32'd0);

    // same image, random ByteValid, stray Start inside DATA
    clear_log(); do_start();
    send(1, 4); wait_finish();
    check_image("t2_img");
    chk("t2_done", 32'(Done), 32'd1);

    // Start from DONE reasserts CpuHold on the next cycle and reloads
    clear_log();
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    chk("t3_hold", 32'(CpuHold), 32'd1);
    chk("t3_done", 32'(Done), 32'd0);
    chk("t3_busy", 32'(Busy), 32'd1);
    send(0, -1); wait_finish();
    check_image("t3_img");

    // zero-length header
    clear_log(); do_start();
    stream = '{8'h00, 8'h00}; send(1, -1); wait_finish();
    chk("t4_err", 32'(Error), 32'd1);
    chk("t4_hold", 32'(CpuHold), 32'd1);
    chk("t4_we", 32'(we_count), 32'd0);

    // header 33 exceeds depth
    clear_log(); do_start();
    stream = '{8'h21, 8'h00}; send(0, -1); wait_finish();
    chk("t5_err", 32'(Error), 32'd1);
    chk("t5_done", 32'(Done), 32'd0);
    chk("t5_we", 32'(we_count), 32'd0);

    // full-depth image, word i = i
    clear_log(); do_start();
    img.delete();
    for (int i = 0; i < 32; i++) img.push_back(32'(i));
    build(); send(0, -1); wait_finish();
    check_image("t6_img");
    chk("t6_last_addr", last_addr, 32'h7C);
    chk("t6_last_data", last_data, 32'h1F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ByteValid = 1'b1; ByteIn = 8'h55;
    end
    @(negedge clk); ByteValid = 1'b0;
    chk("t6_done_kept", 32'(Done), 32'd1);
    chk("t6_no_extra_we", 32'(we_count), 32'd32);

    // reset after 6 data bytes of a 2-word load
    clear_log(); do_start();
    img = '{32'h11223344, 32'h55667788}; build();
    void'(stream.pop_back()); void'(stream.pop_back());
    send(1, -1);
    repeat (2) @(negedge clk);
    do_reset();
    chk("t7_w0", dut_mem[0], 32'h11223344);
    chk("t7_w1_untouched", dut_mem[1], 32'hDEADDEAD);
    chk("t7_cnt", 32'(we_count), 32'd1);
    clear_log(); do_start();
    img = '{32'hCAFEBABE, 32'h01020304}; build();
    send(1, -1); wait_finish();
    check_image("t7_reload");
    chk("t7_done", 32'(Done), 32'd1);

    // random images
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, 32);
      clear_log(); do_start();
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      build(); send(1, 6); wait_finish();
      check_image("rnd_img");
      chk("rnd_done", 32'(Done), 32'd1);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got %0d passed of %0d", chk_pass, chk_total);
    $fatal(1);
  end

endmodule
